// File: rtl/spi_xfer.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer
// Brief    : Byte-wide full-duplex SPI master shift engine, 4 chip selects.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] clk_div_i,
    input  logic       irq_en_i,
    input  logic [1:0] cs_sel_i,
    input  logic [1:0] mode_i,
    input  logic [7:0] tx_data_i,
    input  logic       start_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic [3:0] cs_n_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       irq_o
);

    localparam logic [4:0] C_LAST_EDGE_IDX = 5'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t     state_q;
    logic       sclk_q;
    logic       mosi_q;
    logic [3:0] cs_n_q;
    logic [7:0] rx_data_q;
    logic       busy_q;
    logic       done_q;
    logic       irq_q;
    logic       irq_pend_q;
    logic       irq_pend_d;
    logic [3:0] h_cnt_q;
    logic [3:0] h_max_q;
    logic [4:0] edge_cnt_q;
    logic       cpol_q;
    logic       cpha_q;
    logic [7:0] tx_sh_q;
    logic [7:0] rx_sh_q;

    logic [3:0] w_h_max;
    logic       w_start_acc;
    logic       w_half_end;
    logic       w_sample;
    logic       w_drive;

    always_comb begin
        case (clk_div_i)
            2'd0:    w_h_max = 4'd1;
            2'd1:    w_h_max = 4'd3;
            2'd2:    w_h_max = 4'd7;
            default: w_h_max = 4'd15;
        endcase
    end

    assign w_start_acc = start_i & ~busy_q;
    assign w_half_end  = (h_cnt_q == 4'd0);
    // edge_cnt_q holds edges already produced, so the upcoming edge is odd when bit 0 is clear
    assign w_sample    = (edge_cnt_q[0] == cpha_q);
    assign w_drive     = ~w_sample & (edge_cnt_q != C_LAST_EDGE_IDX);

    always_comb begin
        irq_pend_d = irq_pend_q;
        if (w_start_acc) begin
            irq_pend_d = 1'b0;
        end else if ((state_q == S_HOLD) && w_half_end) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 4'hF;
            rx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            h_cnt_q    <= 4'd0;
            h_max_q    <= 4'd0;
            edge_cnt_q <= 5'd0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
        end else begin
            done_q     <= 1'b0;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_pend_d & irq_en_i;
            case (state_q)
                S_IDLE: begin
                    sclk_q <= mode_i[1];
                    mosi_q <= 1'b0;
                    cs_n_q <= 4'hF;
                    if (w_start_acc) begin
                        state_q    <= S_SETUP;
                        busy_q     <= 1'b1;
                        cs_n_q     <= ~(4'b0001 << cs_sel_i);
                        cpol_q     <= mode_i[1];
                        cpha_q     <= mode_i[0];
                        h_max_q    <= w_h_max;
                        h_cnt_q    <= w_h_max;
                        edge_cnt_q <= 5'd0;
                        rx_sh_q    <= 8'h00;
                        // CPHA=0 presents the MSB before the first edge
                        if (mode_i[0]) begin
                            mosi_q  <= 1'b0;
                            tx_sh_q <= tx_data_i;
                        end else begin
                            mosi_q  <= tx_data_i[7];
                            tx_sh_q <= {tx_data_i[6:0], 1'b0};
                        end
                    end
                end
                S_SETUP: begin
                    if (w_half_end) begin
                        state_q <= S_SHIFT;
                        h_cnt_q <= h_max_q;
                    end else begin
                        h_cnt_q <= h_cnt_q - 4'd1;
                    end
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        h_cnt_q    <= h_max_q;
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_q + 5'd1;
                        if (w_sample) begin
                            rx_sh_q <= {rx_sh_q[6:0], miso_i};
                        end else if (w_drive) begin
                            mosi_q  <= tx_sh_q[7];
                            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                        end
                        if (edge_cnt_q == C_LAST_EDGE_IDX) begin
                            state_q <= S_HOLD;
                        end
                    end else begin
                        h_cnt_q <= h_cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (w_half_end) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        cs_n_q    <= 4'hF;
                        mosi_q    <= 1'b0;
                        sclk_q    <= cpol_q;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh_q;
                    end else begin
                        h_cnt_q <= h_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;
    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer
// Brief    : Directed self-checking bench for spi_xfer with an SPI slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] clk_div = 2'd0;
    logic       irq_en = 1'b0;
    logic [1:0] cs_sel = 2'd0;
    logic [1:0] mode = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic       start = 1'b0;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic [3:0] cs_n;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       irq;

    int checks = 0;
    int passes = 0;

    // slave model state
    logic       loop_en = 1'b1;
    logic       miso_s = 1'b0;
    logic       s_cpha = 1'b0;
    logic [7:0] s_byte = 8'h00;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         s_edges = 0;
    int         stab_err = 0;
    time        t_mosi = 0;
    logic       cs_prev = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       s_odd;
    logic       cs_act;

    assign miso   = loop_en ? mosi : miso_s;
    assign cs_act = (cs_n != 4'hF);

    spi_xfer dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div_i (clk_div),
        .irq_en_i  (irq_en),
        .cs_sel_i  (cs_sel),
        .mode_i    (mode),
        .tx_data_i (tx_data),
        .start_i   (start),
        .miso_i    (miso),
        .sclk_o    (sclk),
        .mosi_o    (mosi),
        .cs_n_o    (cs_n),
        .rx_data_o (rx_data),
        .busy_o    (busy),
        .done_o    (done),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    always @(mosi) t_mosi = $time;

    always @(sclk or cs_act) begin
        if (cs_act && !cs_prev) begin
            s_edges = 0;
            s_rx    = 8'h00;
            if (s_cpha) begin
                s_sh = s_byte;
            end else begin
                miso_s = s_byte[7];
                s_sh   = {s_byte[6:0], 1'b0};
            end
        end else if (cs_act && (sclk !== sclk_prev)) begin
            s_edges++;
            s_odd = ((s_edges % 2) == 1);
            if (s_odd ^ s_cpha) begin
                if (t_mosi == $time) stab_err++;
                s_rx = {s_rx[6:0], mosi};
            end else if (s_edges < 16) begin
                miso_s = s_sh[7];
                s_sh   = {s_sh[6:0], 1'b0};
            end
        end
        cs_prev   = cs_act;
        sclk_prev = sclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_cfg(input logic [1:0] cd, input logic [1:0] md, input logic [1:0] cs,
                           input logic [7:0] tx, input logic lp, input logic [7:0] sb);
        @(negedge clk);
        clk_div = cd;
        mode    = md;
        cs_sel  = cs;
        tx_data = tx;
        loop_en = lp;
        s_cpha  = md[0];
        s_byte  = sb;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs from cycle 1 until busy drops; returns the first idle cycle number
    task automatic run_xfer(input int h, input logic [3:0] cs_exp, input int inj,
                            output int cyc, output int cs_cnt, output int rises,
                            output int per_err, output int dones);
        int   n;
        int   last_rise;
        logic prev;
        n = 1; cs_cnt = 0; rises = 0; per_err = 0; dones = 0; last_rise = -1;
        prev = sclk;
        while (busy === 1'b1 && n < 1000) begin
            if (cs_n === cs_exp) cs_cnt++;
            if (done === 1'b1) dones++;
            if (sclk === 1'b1 && prev === 1'b0) begin
                rises++;
                if (last_rise >= 0 && (n - last_rise) != 2 * h) per_err++;
                last_rise = n;
            end
            prev = sclk;
            if (n == inj) begin
                start   = 1'b1;
                tx_data = 8'hFF;
                cs_sel  = 2'd3;
                mode    = 2'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        cyc = n;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b0)    $display("FAIL rst_sclk: got %b want 0", sclk); else passes++;
        checks++; if (mosi !== 1'b0)    $display("FAIL rst_mosi: got %b want 0", mosi); else passes++;
        checks++; if (cs_n !== 4'hF)    $display("FAIL rst_cs_n: got %b want 1111", cs_n); else passes++;
        checks++; if (rx_data !== 8'h0) $display("FAIL rst_rx: got %h want 00", rx_data); else passes++;
        checks++; if (busy !== 1'b0)    $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0)    $display("FAIL rst_done: got %b want 0", done); else passes++;
        checks++; if (irq !== 1'b0)     $display("FAIL rst_irq: got %b want 0", irq); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_mode0;
        int cyc, csc, ri, pe, dn;
        set_cfg(2'd0, 2'd0, 2'd0, 8'hA5, 1'b1, 8'h00);
        pulse_start;
        checks++; if (busy !== 1'b1)     $display("FAIL m0_busy_c1: got %b want 1", busy); else passes++;
        checks++; if (cs_n !== 4'b1110)  $display("FAIL m0_cs_c1: got %b want 1110", cs_n); else passes++;
        run_xfer(2, 4'b1110, -1, cyc, csc, ri, pe, dn);
        checks++; if (cyc != 37)         $display("FAIL m0_done_cycle: got %0d want 37", cyc); else passes++;
        checks++; if (csc != 36)         $display("FAIL m0_cs_len: got %0d want 36", csc); else passes++;
        checks++; if (ri != 8)           $display("FAIL m0_sclk_rises: got %0d want 8", ri); else passes++;
        checks++; if (pe != 0)           $display("FAIL m0_sclk_period: got %0d bad want 0", pe); else passes++;
        checks++; if (done !== 1'b1)     $display("FAIL m0_done: got %b want 1", done); else passes++;
        checks++; if (cs_n !== 4'hF)     $display("FAIL m0_cs_end: got %b want 1111", cs_n); else passes++;
        checks++; if (mosi !== 1'b0)     $display("FAIL m0_mosi_end: got %b want 0", mosi); else passes++;
        checks++; if (rx_data !== 8'hA5) $display("FAIL m0_rx: got %h want a5", rx_data); else passes++;
        checks++; if (s_rx !== 8'hA5)    $display("FAIL m0_mosi_seq: got %h want a5", s_rx); else passes++;
        checks++; if (irq !== 1'b0)      $display("FAIL m0_irq_masked: got %b want 0", irq); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0)     $display("FAIL m0_done_pulse: got %b want 0", done); else passes++;
    endtask

    task automatic test_mode3;
        int cyc, csc, ri, pe, dn;
        set_cfg(2'd3, 2'd3, 2'd2, 8'h3C, 1'b0, 8'hC3);
        checks++; if (sclk !== 1'b1)     $display("FAIL m3_sclk_idle: got %b want 1", sclk); else passes++;
        pulse_start;
        checks++; if (cs_n !== 4'b1011)  $display("FAIL m3_cs: got %b want 1011", cs_n); else passes++;
        run_xfer(16, 4'b1011, -1, cyc, csc, ri, pe, dn);
        checks++; if (cyc != 289)        $display("FAIL m3_busy_len: got %0d want 289", cyc); else passes++;
        checks++; if (csc != 288)        $display("FAIL m3_cs_len: got %0d want 288", csc); else passes++;
        checks++; if (ri != 8)           $display("FAIL m3_sclk_rises: got %0d want 8", ri); else passes++;
        checks++; if (pe != 0)           $display("FAIL m3_sclk_period: got %0d bad want 0", pe); else passes++;
        checks++; if (rx_data !== 8'hC3) $display("FAIL m3_rx: got %h want c3", rx_data); else passes++;
        checks++; if (s_rx !== 8'h3C)    $display("FAIL m3_slave_rx: got %h want 3c", s_rx); else passes++;
    endtask

    task automatic test_modes12;
        int cyc, csc, ri, pe, dn, stab0;
        logic [7:0] tx;
        for (int m = 1; m <= 2; m++) begin
            tx = (m == 1) ? 8'h96 : 8'h69;
            set_cfg(2'd1, 2'(m), 2'd1, tx, 1'b0, 8'h5A);
            stab0 = stab_err;
            pulse_start;
            run_xfer(4, 4'b1101, -1, cyc, csc, ri, pe, dn);
            checks++; if (cyc != 73)         $display("FAIL m%0d_busy_len: got %0d want 73", m, cyc); else passes++;
            checks++; if (pe != 0 || ri != 8) $display("FAIL m%0d_sclk: got %0d rises %0d bad want 8 0", m, ri, pe); else passes++;
            checks++; if (rx_data !== 8'h5A) $display("FAIL m%0d_rx: got %h want 5a", m, rx_data); else passes++;
            checks++; if (s_rx !== tx)       $display("FAIL m%0d_slave_rx: got %h want %h", m, s_rx, tx); else passes++;
            checks++; if (stab_err != stab0) $display("FAIL m%0d_mosi_stable: got %0d want %0d", m, stab_err, stab0); else passes++;
        end
    endtask

    task automatic test_busy_ignore;
        int cyc, csc, ri, pe, dn, extra_done, extra_busy;
        set_cfg(2'd0, 2'd0, 2'd1, 8'h81, 1'b1, 8'h00);
        pulse_start;
        run_xfer(2, 4'b1101, 10, cyc, csc, ri, pe, dn);
        checks++; if (cyc != 37)         $display("FAIL bi_done_cycle: got %0d want 37", cyc); else passes++;
        checks++; if (csc != 36)         $display("FAIL bi_cs_len: got %0d want 36", csc); else passes++;
        checks++; if (rx_data !== 8'h81) $display("FAIL bi_rx: got %h want 81", rx_data); else passes++;
        checks++; if (s_rx !== 8'h81)    $display("FAIL bi_mosi_byte: got %h want 81", s_rx); else passes++;
        checks++; if (dn != 0)           $display("FAIL bi_early_done: got %0d want 0", dn); else passes++;
        checks++; if (done !== 1'b1)     $display("FAIL bi_done: got %b want 1", done); else passes++;
        extra_done = 0; extra_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        checks++; if (extra_done != 0)   $display("FAIL bi_extra_done: got %0d want 0", extra_done); else passes++;
        checks++; if (extra_busy != 0)   $display("FAIL bi_queued: got %0d want 0", extra_busy); else passes++;
    endtask

    task automatic test_irq;
        int cyc, csc, ri, pe, dn;
        set_cfg(2'd0, 2'd0, 2'd0, 8'h5A, 1'b1, 8'h00);
        irq_en = 1'b1;
        @(negedge clk);
        checks++; if (irq !== 1'b1)   $display("FAIL irq_unmask_pending: got %b want 1", irq); else passes++;
        pulse_start;
        checks++; if (irq !== 1'b0)   $display("FAIL irq_start_clear: got %b want 0", irq); else passes++;
        run_xfer(2, 4'b1110, -1, cyc, csc, ri, pe, dn);
        checks++; if (cyc != 37)      $display("FAIL irq_done_cycle: got %0d want 37", cyc); else passes++;
        checks++; if (irq !== 1'b1)   $display("FAIL irq_at_done: got %b want 1", irq); else passes++;
        irq_en = 1'b0;
        @(negedge clk);
        checks++; if (irq !== 1'b0)   $display("FAIL irq_mask: got %b want 0", irq); else passes++;
        irq_en = 1'b1;
        @(negedge clk);
        checks++; if (irq !== 1'b1)   $display("FAIL irq_remask: got %b want 1", irq); else passes++;
        irq_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        int cyc, csc, ri, pe, dn, late_done;
        set_cfg(2'd0, 2'd0, 2'd3, 8'h3C, 1'b1, 8'h00);
        pulse_start;
        for (int n = 1; n < 17; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cs_n !== 4'hF)    $display("FAIL rm_cs: got %b want 1111", cs_n); else passes++;
        checks++; if (busy !== 1'b0)    $display("FAIL rm_busy: got %b want 0", busy); else passes++;
        checks++; if (sclk !== 1'b0)    $display("FAIL rm_sclk: got %b want 0", sclk); else passes++;
        checks++; if (rx_data !== 8'h0) $display("FAIL rm_rx: got %h want 00", rx_data); else passes++;
        rst = 1'b0;
        late_done = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) late_done++;
            @(negedge clk);
        end
        checks++; if (late_done != 0)   $display("FAIL rm_no_done: got %0d want 0", late_done); else passes++;
        set_cfg(2'd0, 2'd0, 2'd3, 8'hC6, 1'b1, 8'h00);
        pulse_start;
        run_xfer(2, 4'b0111, -1, cyc, csc, ri, pe, dn);
        checks++; if (cyc != 37 || csc != 36) $display("FAIL rm_next_len: got %0d/%0d want 37/36", cyc, csc); else passes++;
        checks++; if (done !== 1'b1)     $display("FAIL rm_next_done: got %b want 1", done); else passes++;
        checks++; if (rx_data !== 8'hC6) $display("FAIL rm_next_rx: got %h want c6", rx_data); else passes++;
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_modes12;
        test_busy_ignore;
        test_irq;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
